// File: rtl/rc5_pkg.sv
// Shared sizing, magic constants and encodings for the RC5-32/12/16 key schedule.
package rc5_pkg;

    localparam int W         = 32;
    localparam int B         = 16;
    localparam int B_LENGTH  = 4;
    localparam int U         = W / 8;
    localparam int C         = B / U;
    localparam int C_LENGTH  = 2;
    localparam int R         = 12;
    localparam int T         = 2 * R + 2;
    localparam int T_LENGTH  = 5;
    localparam int LOG_W     = $clog2(W);
    localparam int MIX_ITERS = 3 * ((T > C) ? T : C);
    localparam int CNT_W     = 8;

    localparam logic [W-1:0] P_W = 32'hB7E15163;
    localparam logic [W-1:0] Q_W = 32'h9E3779B9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR_L = 3'd1,
        ST_LOAD_L  = 3'd2,
        ST_INIT_S  = 3'd3,
        ST_MIX     = 3'd4,
        ST_DONE    = 3'd5
    } ks_state_e;

    typedef enum logic {
        PH_S = 1'b0,
        PH_L = 1'b1
    } mix_phase_e;

endpackage

// File: rtl/rc5_rotl.sv
// Combinational variable rotate-left of a W-bit word.
module rc5_rotl #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic [W-1:0]  data_i,
    input  logic [AW-1:0] amt_i,
    output logic [W-1:0]  data_o
);

    // A right shift by the full width yields zero, so amount 0 passes data through.
    assign data_o = (data_i << amt_i) | (data_i >> (W - int'(amt_i)));

endmodule

// File: rtl/rc5_key_schedule_ctrl.sv
// RC5 key expansion sequencer: owns the L and S RAM ports and the key-byte address.
// Define RC5_KS_CLEAR_L_EN to keep the explicit CLEAR_L pass over L.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR_L | zero L[0..c-1]                (RC5_KS_CLEAR_L_EN only)
// LOAD_L  | pack key bytes b-1..0 into L
// INIT_S  | S[k] = P + k*Q
// MIX     | 3*max(t,c) two-cycle mixing iterations
// DONE    | one-cycle done pulse
module rc5_key_schedule_ctrl
    import rc5_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [B_LENGTH-1:0] key_address,
    input  logic [7:0]          key_byte_i,
    output logic [C_LENGTH-1:0] L_address,
    input  logic [W-1:0]        L_rdata,
    output logic [W-1:0]        L_wdata,
    output logic                L_we,
    output logic [T_LENGTH-1:0] S_address,
    input  logic [W-1:0]        S_rdata,
    output logic [W-1:0]        S_wdata,
    output logic                S_we
);

    localparam logic [LOG_W-1:0] ROT_A = LOG_W'(3);

    ks_state_e           state_q, state_d;
    mix_phase_e          phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]        run_q, run_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [T_LENGTH-1:0] i_q, i_d;
    logic [C_LENGTH-1:0] j_q, j_d;

    logic [W-1:0]     s_sum, l_sum, rot_a, rot_b, old_word;
    logic [LOG_W-1:0] rot_b_amt;

    assign s_sum     = S_rdata + a_q + b_q;
    assign l_sum     = L_rdata + a_q + b_q;
    assign rot_b_amt = LOG_W'(a_q + b_q);

    rc5_rotl #(.W(W), .AW(LOG_W)) u_rotl_a (
        .data_i (s_sum),
        .amt_i  (ROT_A),
        .data_o (rot_a)
    );

    rc5_rotl #(.W(W), .AW(LOG_W)) u_rotl_b (
        .data_i (l_sum),
        .amt_i  (rot_b_amt),
        .data_o (rot_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_S;
            cnt_q   <= '0;
            run_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        run_d       = run_q;
        a_d         = a_q;
        b_d         = b_q;
        i_d         = i_q;
        j_d         = j_q;
        busy        = 1'b0;
        done        = 1'b0;
        key_address = '0;
        L_address   = '0;
        L_wdata     = '0;
        L_we        = 1'b0;
        S_address   = '0;
        S_wdata     = '0;
        S_we        = 1'b0;
        old_word    = L_rdata;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef RC5_KS_CLEAR_L_EN
                    state_d = ST_CLEAR_L;
                    cnt_d   = '0;
`else
                    state_d = ST_LOAD_L;
                    cnt_d   = CNT_W'(B - 1);
`endif
                end
            end
`ifdef RC5_KS_CLEAR_L_EN
            ST_CLEAR_L: begin
                busy      = 1'b1;
                L_address = C_LENGTH'(cnt_q);
                L_we      = 1'b1;
                if (cnt_q == CNT_W'(C - 1)) begin
                    state_d = ST_LOAD_L;
                    cnt_d   = CNT_W'(B - 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_LOAD_L: begin
                busy        = 1'b1;
                key_address = B_LENGTH'(cnt_q);
                L_address   = C_LENGTH'(cnt_q / CNT_W'(U));
`ifndef RC5_KS_CLEAR_L_EN
                // Without the clear pass, the top byte of each word starts from zero.
                if ((cnt_q % CNT_W'(U)) == CNT_W'(U - 1))
                    old_word = '0;
`endif
                L_wdata = (old_word << 8) + W'(key_byte_i);
                L_we    = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_INIT_S;
                    run_d   = P_W;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INIT_S: begin
                busy      = 1'b1;
                S_address = T_LENGTH'(cnt_q);
                S_wdata   = run_q;
                S_we      = 1'b1;
                run_d     = run_q + Q_W;
                if (cnt_q == CNT_W'(T - 1)) begin
                    state_d = ST_MIX;
                    phase_d = PH_S;
                    cnt_d   = CNT_W'(MIX_ITERS - 1);
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MIX: begin
                busy = 1'b1;
                if (phase_q == PH_S) begin
                    S_address = i_q;
                    S_wdata   = rot_a;
                    S_we      = 1'b1;
                    a_d       = rot_a;
                    phase_d   = PH_L;
                end else begin
                    L_address = j_q;
                    L_wdata   = rot_b;
                    L_we      = 1'b1;
                    b_d       = rot_b;
                    phase_d   = PH_S;
                    i_d       = (i_q == T_LENGTH'(T - 1)) ? '0 : i_q + 1'b1;
                    j_d       = (j_q == C_LENGTH'(C - 1)) ? '0 : j_q + 1'b1;
                    if (cnt_q == '0)
                        state_d = ST_DONE;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc5_key_schedule_ctrl.sv
// Self-checking bench for rc5_key_schedule_ctrl against a plain RC5 key-expansion model.
module tb_rc5_key_schedule_ctrl;

    localparam int KEY_BYTES = 16;
    localparam int L_WORDS   = 4;
    localparam int S_WORDS   = 26;
`ifdef RC5_KS_CLEAR_L_EN
    localparam int CLR_CYC = 4;
`else
    localparam int CLR_CYC = 0;
`endif
    localparam int MIX0     = CLR_CYC + KEY_BYTES + S_WORDS + 1;
    localparam int EXP_DONE = CLR_CYC + KEY_BYTES + S_WORDS + 6 * S_WORDS + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, L_we, S_we;
    logic [3:0]  key_address;
    logic [7:0]  key_byte_i;
    logic [1:0]  L_address;
    logic [4:0]  S_address;
    logic [31:0] L_rdata, L_wdata, S_rdata, S_wdata;

    logic [7:0]  key_mem [KEY_BYTES];
    logic [31:0] l_ram [4];
    logic [31:0] s_ram [32];

    int checks = 0;
    int failures = 0;

    // model results
    logic [31:0] exp_L_load [L_WORDS];
    logic [31:0] exp_S_init [S_WORDS];
    logic [31:0] exp_L_fin [L_WORDS];
    logic [31:0] exp_S_fin [S_WORDS];
    logic [31:0] exp_first_s, exp_first_l;

    // observations from run_exp
    int          obs_done_n, obs_busy_err, obs_idle_err, obs_s_n, obs_l_n, obs_addr_err;
    int          obs_done_c [2];
    logic [31:0] snap_L [L_WORDS];
    logic [31:0] snap_S [3];
    logic [31:0] obs_first_s, obs_first_l;
    logic        obs_rst_busy, obs_rst_done, obs_rst_lwe, obs_rst_swe;

    always #5 clk = ~clk;

    assign key_byte_i = key_mem[key_address];
    assign L_rdata    = l_ram[L_address];
    assign S_rdata    = s_ram[S_address];

    always @(posedge clk) begin
        if (L_we) l_ram[L_address] <= L_wdata;
        if (S_we) s_ram[S_address] <= S_wdata;
    end

    rc5_key_schedule_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .key_address (key_address),
        .key_byte_i  (key_byte_i),
        .L_address   (L_address),
        .L_rdata     (L_rdata),
        .L_wdata     (L_wdata),
        .L_we        (L_we),
        .S_address   (S_address),
        .S_rdata     (S_rdata),
        .S_wdata     (S_wdata),
        .S_we        (S_we)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
    endfunction

    task automatic compute_model();
        logic [31:0] lm [L_WORDS];
        logic [31:0] sm [S_WORDS];
        logic [31:0] a, bv;
        int          ii, jj;
        for (int k = 0; k < L_WORDS; k++) lm[k] = '0;
        for (int x = 0; x < KEY_BYTES; x++)
            lm[x / 4] = lm[x / 4] + (32'(key_mem[x]) << (8 * (x % 4)));
        for (int k = 0; k < S_WORDS; k++)
            sm[k] = 32'hB7E15163 + 32'(k) * 32'h9E3779B9;
        for (int k = 0; k < L_WORDS; k++) exp_L_load[k] = lm[k];
        for (int k = 0; k < S_WORDS; k++) exp_S_init[k] = sm[k];
        a = '0; bv = '0; ii = 0; jj = 0;
        for (int n = 0; n < 3 * S_WORDS; n++) begin
            sm[ii] = rotl(sm[ii] + a + bv, 3);
            a = sm[ii];
            lm[jj] = rotl(lm[jj] + a + bv, int'((a + bv) & 32'd31));
            bv = lm[jj];
            if (n == 0) begin
                exp_first_s = a;
                exp_first_l = bv;
            end
            ii = (ii + 1) % S_WORDS;
            jj = (jj + 1) % L_WORDS;
        end
        for (int k = 0; k < L_WORDS; k++) exp_L_fin[k] = lm[k];
        for (int k = 0; k < S_WORDS; k++) exp_S_fin[k] = sm[k];
    endtask

    task automatic random_key();
        for (int x = 0; x < KEY_BYTES; x++) key_mem[x] = 8'($urandom_range(255));
    endtask

    // Starts one expansion and observes it cycle by cycle (cycle 1 = first cycle after the accepting edge).
    task automatic run_exp(input int p1, input int p2, input int p3, input bit hold,
                           input int rst_at, input int ncyc);
        int cyc;
        obs_done_n = 0; obs_busy_err = 0; obs_idle_err = 0;
        obs_s_n = 0; obs_l_n = 0; obs_addr_err = 0;
        obs_done_c[0] = -1; obs_done_c[1] = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < ncyc) begin
            @(negedge clk);
            cyc++;
            start = (hold && cyc < 2 * EXP_DONE + 2) || cyc == p1 || cyc == p2 || cyc == p3;
            if (cyc == rst_at) begin
                rst = 1'b0;
                #1;
                obs_rst_busy = busy;
                obs_rst_done = done;
                obs_rst_lwe  = L_we;
                obs_rst_swe  = S_we;
                break;
            end
            if (done) begin
                if (obs_done_n < 2) obs_done_c[obs_done_n] = cyc;
                obs_done_n++;
            end
            if (cyc <= EXP_DONE + 1 && busy !== (cyc < EXP_DONE)) obs_busy_err++;
            if (cyc == EXP_DONE + 1 && (L_we || S_we || done)) obs_idle_err++;
            if (cyc == CLR_CYC + KEY_BYTES + 1)
                for (int k = 0; k < L_WORDS; k++) snap_L[k] = l_ram[k];
            if (cyc == MIX0) begin
                for (int k = 0; k < 3; k++) snap_S[k] = s_ram[k];
                obs_first_s = S_wdata;
            end
            if (cyc == MIX0 + 1) obs_first_l = L_wdata;
            if (cyc >= MIX0 && cyc < EXP_DONE) begin
                if (S_we) begin
                    if (int'(S_address) != obs_s_n % S_WORDS) obs_addr_err++;
                    obs_s_n++;
                end
                if (L_we) begin
                    if (int'(L_address) != obs_l_n % L_WORDS) obs_addr_err++;
                    obs_l_n++;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (L_we !== 1'b0) begin failures++; $display("FAIL reset_L_we: got %b expected 0", L_we); end
        checks++; if (S_we !== 1'b0) begin failures++; $display("FAIL reset_S_we: got %b expected 0", S_we); end
        checks++; if ({key_address, L_address, S_address} !== 11'd0) begin failures++; $display("FAIL reset_addr: got %h expected 0", {key_address, L_address, S_address}); end
        checks++; if ({L_wdata, S_wdata} !== 64'd0) begin failures++; $display("FAIL reset_wdata: got %h expected 0", {L_wdata, S_wdata}); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_run_common(input string tag);
        checks++; if (obs_done_c[0] != EXP_DONE) begin failures++; $display("FAIL %s_done_cycle: got %0d expected %0d", tag, obs_done_c[0], EXP_DONE); end
        checks++; if (obs_busy_err != 0) begin failures++; $display("FAIL %s_busy_window: got %0d bad cycles expected 0", tag, obs_busy_err); end
        checks++; if (obs_idle_err != 0) begin failures++; $display("FAIL %s_idle_after_done: got %0d expected 0", tag, obs_idle_err); end
        for (int k = 0; k < L_WORDS; k++) begin
            checks++; if (l_ram[k] !== exp_L_fin[k]) begin failures++; $display("FAIL %s_final_L%0d: got %h expected %h", tag, k, l_ram[k], exp_L_fin[k]); end
        end
        for (int k = 0; k < S_WORDS; k++) begin
            checks++; if (s_ram[k] !== exp_S_fin[k]) begin failures++; $display("FAIL %s_final_S%0d: got %h expected %h", tag, k, s_ram[k], exp_S_fin[k]); end
        end
    endtask

    task automatic test_counting_key();
        for (int x = 0; x < KEY_BYTES; x++) key_mem[x] = 8'(x);
        compute_model();
        run_exp(-1, -1, -1, 1'b0, -1, EXP_DONE + 4);
        for (int k = 0; k < L_WORDS; k++) begin
            checks++; if (snap_L[k] !== exp_L_load[k]) begin failures++; $display("FAIL load_L%0d: got %h expected %h", k, snap_L[k], exp_L_load[k]); end
        end
        for (int k = 0; k < 3; k++) begin
            checks++; if (snap_S[k] !== exp_S_init[k]) begin failures++; $display("FAIL init_S%0d: got %h expected %h", k, snap_S[k], exp_S_init[k]); end
        end
        checks++; if (obs_first_s !== exp_first_s) begin failures++; $display("FAIL first_mix_S: got %h expected %h", obs_first_s, exp_first_s); end
        checks++; if (obs_first_l !== exp_first_l) begin failures++; $display("FAIL first_mix_L: got %h expected %h", obs_first_l, exp_first_l); end
        checks++; if (obs_s_n != 78 || obs_l_n != 78) begin failures++; $display("FAIL mix_write_count: got S=%0d L=%0d expected 78/78", obs_s_n, obs_l_n); end
        checks++; if (obs_addr_err != 0) begin failures++; $display("FAIL mix_wrap_addr: got %0d bad addresses expected 0", obs_addr_err); end
        check_run_common("count_key");
    endtask

    task automatic test_random_keys();
        for (int n = 0; n < 3; n++) begin
            random_key();
            compute_model();
            run_exp(-1, -1, -1, 1'b0, -1, EXP_DONE + 4);
            for (int k = 0; k < L_WORDS; k++) begin
                checks++; if (snap_L[k] !== exp_L_load[k]) begin failures++; $display("FAIL rand_load_L%0d: got %h expected %h", k, snap_L[k], exp_L_load[k]); end
            end
            check_run_common("rand_key");
        end
    endtask

    task automatic test_ignored_start();
        random_key();
        compute_model();
        run_exp(50, EXP_DONE - 1, EXP_DONE, 1'b0, -1, EXP_DONE + 6);
        checks++; if (obs_done_n != 1) begin failures++; $display("FAIL ignored_start_pulses: got %0d done pulses expected 1", obs_done_n); end
        check_run_common("ignored_start");
    endtask

    task automatic test_reset_mid_mix();
        random_key();
        compute_model();
        run_exp(-1, -1, -1, 1'b0, MIX0 + 60, EXP_DONE + 4);
        checks++; if (obs_rst_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", obs_rst_busy); end
        checks++; if (obs_rst_done !== 1'b0) begin failures++; $display("FAIL midreset_done: got %b expected 0", obs_rst_done); end
        checks++; if ({obs_rst_lwe, obs_rst_swe} !== 2'b00) begin failures++; $display("FAIL midreset_we: got %b expected 00", {obs_rst_lwe, obs_rst_swe}); end
        @(negedge clk);
        rst = 1'b1;
        run_exp(-1, -1, -1, 1'b0, -1, EXP_DONE + 4);
        check_run_common("after_reset");
    endtask

    task automatic test_back_to_back();
        random_key();
        compute_model();
        run_exp(-1, -1, -1, 1'b1, -1, 2 * EXP_DONE + 4);
        checks++; if (obs_done_n != 2) begin failures++; $display("FAIL b2b_done_count: got %0d expected 2", obs_done_n); end
        checks++; if (obs_done_c[1] != 2 * EXP_DONE + 1) begin failures++; $display("FAIL b2b_second_done: got %0d expected %0d", obs_done_c[1], 2 * EXP_DONE + 1); end
        check_run_common("b2b");
    endtask

    initial begin
        for (int k = 0; k < 4; k++) l_ram[k] = '0;
        for (int k = 0; k < 32; k++) s_ram[k] = '0;
        for (int x = 0; x < KEY_BYTES; x++) key_mem[x] = '0;
        test_reset();
        test_counting_key();
        test_random_keys();
        test_ignored_start();
        test_reset_mid_mix();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rc5_key_schedule_ctrl.md
# rc5_key_schedule_ctrl

Sequencer for the RC5-w/r/b key expansion. It owns the L (key-word) RAM and the S (expanded-key) table RAM, and drives the key-byte source. In order, it clears L, packs key bytes into L words, initialises S with the P/Q magic constants, and runs the 3·max(t,c) mixing loop. It sits between the key-byte store and the encrypt/decrypt round datapath, which may read S only after `done`.

## Interface
- `w`, 32: word width.
- `b`, 16: key length in bytes.
- `b_length`, 4: key address width.
- `u`, 4: bytes per word (w/8).
- `c`, 4: L words (b/u).
- `c_length`, 2: L address width.
- `r`, 12: rounds.
- `t`, 26: S words (2r+2).
- `t_length`, 5: S address width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request expansion; sampled only in IDLE.
- `busy`  out  1  high from the cycle after start acceptance until the last MIX cycle.
- `done`  out  1  one-cycle pulse after expansion completes.
- `key_address`  out  b_length  key byte index.
- `key_byte_i`  in  8  key byte, combinational read.
- `L_address`  out  c_length  L RAM address.
- `L_rdata`  in  w  L RAM read data, combinational.
- `L_wdata`  out  w  L write data.
- `L_we`  out  1  L write enable, written on the clock edge.
- `S_address`  out  t_length  S RAM address.
- `S_rdata`  in  w  S RAM read data, combinational.
- `S_wdata`  out  w  S write data.
- `S_we`  out  1  S write enable.

## Operation
- States: IDLE → CLEAR_L → LOAD_L → INIT_S → MIX → DONE → IDLE.
- **IDLE**
  - `start`=1 → CLEAR_L.
  - Otherwise hold.
- **CLEAR_L**, c cycles
  - `L_address` = 0..c-1, `L_wdata` = 0, `L_we` = 1.
- **LOAD_L**, b cycles, i = b-1 down to 0
  - `key_address` = i, `L_address` = i/u.
  - `L_wdata` = (`L_rdata` << 8) + `key_byte_i`, truncated to w bits.
- **INIT_S**, t cycles, k = 0..t-1
  - `S_wdata` = P_W for k=0; otherwise previous value + Q_W, mod 2^w.
  - A running register carries the previous value. S is never read back in this state.
- **MIX**: registers A, B, i, j cleared on entry. 3·max(t,c) iterations, two cycles each:
  - Phase 0: `S_address` = i. A' = rotl(`S_rdata`+A+B, 3). Write S[i] = A'. Register A = A'.
  - Phase 1: `L_address` = j. B' = rotl(`L_rdata`+A+B, (A+B)[log2(w)-1:0]). Write L[j] = B'. Register B = B'.
  - After phase 1: i = (i+1) mod t, j = (j+1) mod c. Wrap occurs at index t-1 and c-1, not at a power of two.
  - All additions are mod 2^w.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `start` while busy or in DONE is ignored; no restart or queueing.
- Write enables and `done` are low in every state not listed above.
- Reset mid-operation:
  - FSM returns to IDLE immediately.
  - RAM contents are left as-is and are invalid.
  - A new `start` reruns the full sequence.

## Timing
- Reset values: `busy`=0, `done`=0, `L_we`=0, `S_we`=0. All addresses and write data 0. A, B, i, j and counters 0.
- Take the edge that accepts `start` as cycle 0:
  - CLEAR_L occupies cycles 1..c.
  - LOAD_L follows for b cycles, then INIT_S for t cycles, then MIX for 6·max(t,c) cycles.
  - `done` is high on cycle c+b+t+6·max(t,c)+1. With defaults that is cycle 203.
- `busy` is high on cycles 1..202 with defaults.
- `start` held high continuously starts a new expansion on the cycle after DONE.

## Configuration
- `RC5_KS_CLEAR_L_EN` defined: the CLEAR_L state exists, as described above.
- Undefined:
  - CLEAR_L is removed and IDLE goes straight to LOAD_L.
  - On the first byte written to each word (i mod u == u-1), the old-word term is 0 instead of `L_rdata`.
  - L contents are identical; latency drops by c. `done` is on cycle 199 with defaults.

## Structure
- Package `rc5_pkg` holds:
  - constants P_W = 32'hB7E15163 and Q_W = 32'h9E3779B9;
  - the state encoding (IDLE, CLEAR_L, LOAD_L, INIT_S, MIX, DONE);
  - the MIX phase encoding.
- Sub-module `rc5_rotl`: combinational w-bit variable rotate-left, with amount width log2(w). It is instantiated twice: fixed amount 3, and amount (A+B).

## Test plan
- Reset asserted mid-MIX → next cycle `busy`=0, `done`=0, both write enables 0; a following `start` yields `done` on cycle 203.
- Key bytes K[i]=i, `start` → after LOAD_L, L[0]=0x03020100 and L[3]=0x0F0E0D0C. The same result holds with the macro undefined.
- Any key → after INIT_S, S[0]=0xB7E15163, S[1]=0x5618CB1C, S[2]=0xF45044D5.
- Key K[i]=i → first MIX iteration writes S[0]=0xBF0A8B1D, then L[0]=0xB8419183 (rotate amount 29).
- `start` pulsed on cycles 50 and 202 → both ignored. Exactly one `done` pulse appears, on cycle 203.
- MIX index wrap → S writes cycle 0..25 and back to 0; L writes cycle 0..3 and back to 0. Exactly 78 S writes and 78 L writes occur in MIX.
